// File: rtl/frame_playback_overlay.sv
// frame_playback_overlay: realigns raster counters to BRAM read latency, expands RGB332 to RGB888, overlays a button-steered crop box
// Ports: clk/rst (async active-high); hcount/vcount raster position; hoffset/voffset frame origin;
//        in_display frame window flag; bram_dout RGB332 pixel; bram_state capture state (2'b11 = reading);
//        live_pixel camera pixel; btn_* debounced buttons; pixel_out/out_display video out; box_x/box_y crop box origin.
// Optional: define OUTSIDE_DIM_EN to halve every channel of in-window pixels outside the crop box.
module frame_playback_overlay #(
    parameter int FRAME_W = 640,
    parameter int FRAME_H = 400,
    parameter int BOX_W = 210,
    parameter int BOX_H = 270,
    parameter int STEP = 4,
    parameter int BORDER = 2,
    parameter logic [23:0] BORDER_COLOR = 24'hFF0000,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [10:0] hoffset,
    input  logic [9:0]  voffset,
    input  logic        in_display,
    input  logic [7:0]  bram_dout,
    input  logic [1:0]  bram_state,
    input  logic [23:0] live_pixel,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [23:0] pixel_out,
    output logic        out_display,
    output logic [9:0]  box_x,
    output logic [8:0]  box_y
);
    localparam int XMAX = FRAME_W - BOX_W;
    localparam int YMAX = FRAME_H - BOX_H;

    logic [10:0] h_d [RD_LAT];
    logic [9:0]  v_d [RD_LAT];
    logic        disp_d [RD_LAT];
    logic [1:0]  st_d [RD_LAT];
    logic [23:0] live_d [RD_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                h_d[i] <= '0;
                v_d[i] <= '0;
                disp_d[i] <= 1'b0;
                st_d[i] <= '0;
                live_d[i] <= '0;
            end
        end else begin
            h_d[0] <= hcount;
            v_d[0] <= vcount;
            disp_d[0] <= in_display;
            st_d[0] <= bram_state;
            live_d[0] <= live_pixel;
            for (int i = 1; i < RD_LAT; i++) begin
                h_d[i] <= h_d[i-1];
                v_d[i] <= v_d[i-1];
                disp_d[i] <= disp_d[i-1];
                st_d[i] <= st_d[i-1];
                live_d[i] <= live_d[i-1];
            end
        end
    end

    // Stage RD_LAT: the delayed counters line up with bram_dout here.
    // Coordinates are widened to 12 bits so box_x+BOX_W never wraps.
    logic [11:0] lx, ly, bx, by;
    logic        in_box, border;
    logic [23:0] expanded, src, shaded, next_px;

    always_comb begin
        lx = {1'b0, h_d[RD_LAT-1] - hoffset};
        ly = {2'b0, v_d[RD_LAT-1] - voffset};
        bx = {2'b0, box_x};
        by = {3'b0, box_y};
        in_box = lx >= bx && lx < bx + 12'(BOX_W) && ly >= by && ly < by + 12'(BOX_H);
        border = in_box && (lx < bx + 12'(BORDER) || lx >= bx + 12'(BOX_W - BORDER) ||
                            ly < by + 12'(BORDER) || ly >= by + 12'(BOX_H - BORDER));
        expanded = {bram_dout[7:5], bram_dout[7:5], bram_dout[7:6],
                    bram_dout[4:2], bram_dout[4:2], bram_dout[4:3],
                    {4{bram_dout[1:0]}}};
        src = st_d[RD_LAT-1] == 2'b11 ? expanded : live_d[RD_LAT-1];
`ifdef OUTSIDE_DIM_EN
        shaded = in_box ? src : {1'b0, src[23:17], 1'b0, src[15:9], 1'b0, src[7:1]};
`else
        shaded = src;
`endif
        next_px = !disp_d[RD_LAT-1] ? 24'h0 : border ? BORDER_COLOR : shaded;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_out <= '0;
            out_display <= 1'b0;
        end else begin
            pixel_out <= next_px;
            out_display <= disp_d[RD_LAT-1];
        end
    end

    // Buttons ordered {up, down, left, right}; pending flags are sticky until the update point.
    logic [3:0]  btn, prev, pend, rise;
    logic        upd;
    logic [10:0] x_inc, y_inc;
    logic [9:0]  x_r, x_l, nx;
    logic [8:0]  y_d, y_u, ny;

    always_comb begin
        btn = {btn_up, btn_down, btn_left, btn_right};
        rise = btn & ~prev;
        upd = {1'b0, vcount} == {1'b0, voffset} + 11'(FRAME_H) && hcount == '0;
        x_inc = {1'b0, box_x} + 11'(STEP);
        y_inc = {2'b0, box_y} + 11'(STEP);
        x_r = x_inc > 11'(XMAX) ? 10'(XMAX) : x_inc[9:0];
        x_l = box_x < 10'(STEP) ? '0 : box_x - 10'(STEP);
        y_d = y_inc > 11'(YMAX) ? 9'(YMAX) : y_inc[8:0];
        y_u = box_y < 9'(STEP) ? '0 : box_y - 9'(STEP);
        // Opposing requests on one axis cancel.
        nx = pend[0] && !pend[1] ? x_r : pend[1] && !pend[0] ? x_l : box_x;
        ny = pend[2] && !pend[3] ? y_d : pend[3] && !pend[2] ? y_u : box_y;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
            pend <= '0;
            box_x <= 10'(XMAX / 2);
            box_y <= 9'(YMAX / 2);
        end else begin
            prev <= btn;
            // An edge on the update cycle itself survives into the next frame.
            pend <= upd ? rise : pend | rise;
            if (upd) begin
                box_x <= nx;
                box_y <= ny;
            end
        end
    end
endmodule

// File: tb/tb_frame_playback_overlay.sv
// tb_frame_playback_overlay: randomized and directed checks of frame_playback_overlay against a behavioural model
module tb_frame_playback_overlay;
    localparam int RD_LAT = 2;
    localparam int HOFF = 40;
    localparam int VOFF = 30;
`ifdef OUTSIDE_DIM_EN
    localparam bit DIM = 1'b1;
`else
    localparam bit DIM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        in_display = 1'b0;
    logic [7:0]  bram_dout = '0;
    logic [1:0]  bram_state = '0;
    logic [23:0] live_pixel = '0;
    logic [3:0]  btn = '0;
    logic [23:0] pixel_out;
    logic        out_display;
    logic [9:0]  box_x;
    logic [8:0]  box_y;

    frame_playback_overlay #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
        .hoffset(11'(HOFF)), .voffset(10'(VOFF)), .in_display(in_display),
        .bram_dout(bram_dout), .bram_state(bram_state), .live_pixel(live_pixel),
        .btn_up(btn[3]), .btn_down(btn[2]), .btn_left(btn[1]), .btn_right(btn[0]),
        .pixel_out(pixel_out), .out_display(out_display), .box_x(box_x), .box_y(box_y)
    );

    always #5 clk = ~clk;

    typedef struct {int h; int v; bit ind; logic [1:0] st; logic [23:0] live;} px_t;
    px_t hist[$];
    int n_chk = 0;
    int n_fail = 0;
    int mbx, mby;
    logic [3:0] mprev, mpend;

    task automatic chk(string tag, logic [23:0] obs, logic [23:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] ref_px(px_t p, logic [7:0] d, int bx, int by);
        int lx, ly;
        logic [23:0] s;
        bit inb, brd;
        if (!p.ind) return '0;
        lx = (p.h - HOFF) & 2047;
        ly = (p.v - VOFF) & 1023;
        s = p.st == 2'b11 ? {8'(int'(d[7:5]) * 73 / 2), 8'(int'(d[4:2]) * 73 / 2), 8'(int'(d[1:0]) * 85)} : p.live;
        inb = lx >= bx && lx < bx + 210 && ly >= by && ly < by + 270;
        brd = inb && (lx < bx + 2 || lx >= bx + 208 || ly < by + 2 || ly >= by + 268);
        if (brd) return 24'hFF0000;
        if (DIM && !inb) return (s >> 1) & 24'h7F7F7F;
        return s;
    endfunction

    function automatic int clampi(int x, int hi);
        return x < 0 ? 0 : x > hi ? hi : x;
    endfunction

    task automatic model_reset();
        px_t z = '{default: 0};
        hist.delete();
        for (int i = 0; i < RD_LAT; i++) hist.push_back(z);
        mprev = '0;
        mpend = '0;
        mbx = 215;
        mby = 65;
    endtask

    // One clock: predict the output from the pixel that entered RD_LAT cycles ago, then compare.
    task automatic tick();
        px_t cur, old;
        logic [23:0] e_px;
        bit e_disp, upd;
        logic [3:0] rise;
        cur = '{h: int'(hcount), v: int'(vcount), ind: in_display, st: bram_state, live: live_pixel};
        hist.push_back(cur);
        old = hist.pop_front();
        e_px = ref_px(old, bram_dout, mbx, mby);
        e_disp = old.ind;
        upd = int'(vcount) == VOFF + 400 && hcount == 0;
        rise = btn & ~mprev;
        if (upd) begin
            mbx = clampi(mbx + 4 * (int'(mpend[0]) - int'(mpend[1])), 430);
            mby = clampi(mby + 4 * (int'(mpend[2]) - int'(mpend[3])), 130);
            mpend = rise;
        end else mpend |= rise;
        mprev = btn;
        @(posedge clk);
        #1;
        chk("pixel", pixel_out, e_px);
        chk("disp", {23'b0, out_display}, {23'b0, e_disp});
        chk("box_x", {14'b0, box_x}, 24'(mbx));
        chk("box_y", {15'b0, box_y}, 24'(mby));
    endtask

    task automatic set_px(int lx, int ly, bit ind, logic [1:0] st, logic [23:0] live);
        hcount = 11'(HOFF + lx);
        vcount = 10'(VOFF + ly);
        in_display = ind;
        bram_state = st;
        live_pixel = live;
    endtask

    task automatic idle();
        set_px(0, 0, 1'b0, 2'b00, 24'h0);
    endtask

    task automatic frame_end();
        hcount = '0;
        vcount = 10'(VOFF + 400);
        in_display = 1'b0;
        tick();
    endtask

    task automatic press(logic [3:0] m);
        idle();
        btn = m;
        tick();
        btn = '0;
        tick();
    endtask

    // Pixel at (lx,ly); dout arrives RD_LAT cycles later; result checked RD_LAT+1 cycles after the coordinate.
    task automatic probe(string tag, int lx, int ly, logic [1:0] st, logic [23:0] live, logic [7:0] d, logic [23:0] exp);
        set_px(lx, ly, 1'b1, st, live);
        bram_dout = 8'h00;
        tick();
        idle();
        tick();
        bram_dout = d;
        tick();
        chk(tag, pixel_out, exp);
    endtask

    task automatic rand_cycles(int n);
        int lx, ly;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                frame_end();
                continue;
            end
            lx = $urandom_range(0, 1) ? mbx - 1 + $urandom_range(0, 4) + ($urandom_range(0, 1) ? 0 : 207) : $urandom_range(0, 639);
            ly = $urandom_range(0, 1) ? mby - 1 + $urandom_range(0, 4) + ($urandom_range(0, 1) ? 0 : 267) : $urandom_range(0, 399);
            set_px(clampi(lx, 639), clampi(ly, 399), $urandom_range(0, 7) != 0,
                   2'($urandom_range(0, 3)), 24'($urandom));
            bram_dout = 8'($urandom);
            if ($urandom_range(0, 7) == 0) btn = 4'($urandom_range(0, 15));
            tick();
        end
        btn = '0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_pixel", pixel_out, 24'h0);
        chk("rst_box_x", {14'b0, box_x}, 24'd215);
        chk("rst_box_y", {15'b0, box_y}, 24'd65);
        idle();
        tick();
        tick();
        probe("expand_e3", 300, 150, 2'b11, 24'h0, 8'hE3, 24'hFF00FF);
        probe("expand_56", 301, 151, 2'b11, 24'h0, 8'h56, 24'h49B6AA);
        probe("border_tl", 215, 65, 2'b01, 24'hABCDEF, 8'h00, 24'hFF0000);
        probe("inner", 217, 67, 2'b01, 24'hABCDEF, 8'h00, 24'hABCDEF);
        probe("border_r", 424, 100, 2'b01, 24'hABCDEF, 8'h00, 24'hFF0000);
        probe("live_out", 10, 10, 2'b01, 24'h123456, 8'hFF, DIM ? 24'h091A2B : 24'h123456);
        rand_cycles(400);
        press(4'b0001);
        frame_end();
        set_px(100, 100, 1'b1, 2'b11, 24'h0);
        btn = 4'hF;
        tick();
        #1 rst = 1'b1;
        #1;
        chk("arst_pixel", pixel_out, 24'h0);
        chk("arst_disp", {23'b0, out_display}, 24'h0);
        chk("arst_box_x", {14'b0, box_x}, 24'd215);
        chk("arst_box_y", {15'b0, box_y}, 24'd65);
        model_reset();
        repeat (2) @(posedge clk);
        btn = '0;
        idle();
        @(negedge clk);
        rst = 1'b0;
        tick();
        frame_end();
        chk("held_no_move", {14'b0, box_x}, 24'd215);
        for (int i = 0; i < 60; i++) begin
            press(4'b0001);
            frame_end();
        end
        chk("clamp_right", {14'b0, box_x}, 24'd430);
        for (int i = 0; i < 120 && mbx != 0; i++) begin
            press(4'b0010);
            frame_end();
        end
        repeat (2) begin
            press(4'b0001);
            frame_end();
        end
        chk("at_8", {14'b0, box_x}, 24'd8);
        for (int i = 0; i < 20; i++) begin
            press(4'b0010);
            frame_end();
        end
        chk("clamp_left", {14'b0, box_x}, 24'd0);
        press(4'b0010);
        press(4'b0001);
        frame_end();
        chk("lr_cancel", {14'b0, box_x}, 24'd0);
        repeat (3) press(4'b0100);
        frame_end();
        chk("multi_down", {15'b0, box_y}, 24'd69);
        btn = 4'b1000;
        frame_end();
        btn = '0;
        idle();
        tick();
        chk("edge_on_upd", {15'b0, box_y}, 24'd69);
        frame_end();
        chk("edge_next", {15'b0, box_y}, 24'd65);
        rand_cycles(800);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
